// File: rtl/prog_loader_ctrl.sv
// Program loader and run controller: streams an image into imem, holds the core's
// PC clear until the load settles, then counts run cycles until halt or budget expiry.
module prog_loader_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned MAX_CYCLES = 100000,
  parameter logic [5:0]  HALT_OP    = 6'h3F
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] core_IR,
  output logic              clr_PC,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   word_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned WC_W   = ADDR_W + 1;
  localparam int unsigned HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_RUN, S_HALTED, S_TIMEOUT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [WC_W-1:0]     r_word_count;
  logic [CNT_W-1:0]    r_cycle_count;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_done;
  logic                r_timeout;

  logic w_accept;
  logic w_halt;
  logic w_budget;
  logic w_start_ok;
  logic w_unused;

  assign w_accept   = ld_valid && (r_state == S_LOAD);
  assign w_halt     = (core_IR[DATA_W-1 -: 6] == HALT_OP);
  assign w_budget   = (r_cycle_count == BUDGET_LAST);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_HALTED) ||
                                (r_state == S_TIMEOUT));
  assign w_unused   = ^core_IR[DATA_W-7:0];

  assign imem_addr   = r_ptr;
  assign imem_wdata  = ld_data;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign word_count  = r_word_count;
  assign cycle_count = r_cycle_count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    clr_PC       = 1'b1;
    busy         = 1'b0;
    ld_ready     = 1'b0;
    imem_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        imem_we  = ld_valid;
        // The top address ends the load even without ld_last so ptr never wraps.
        if (w_accept && (ld_last || (r_ptr == LAST_ADDR))) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (r_hold_cnt == HOLD_LAST) w_next_state = S_RUN;
      end
      S_RUN: begin
        clr_PC = 1'b0;
        busy   = 1'b1;
        if (w_halt)        w_next_state = S_HALTED;
        else if (w_budget) w_next_state = S_TIMEOUT;
      end
      S_HALTED, S_TIMEOUT: begin
        if (start) w_next_state = S_LOAD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Pointers, counters and sticky status flags.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ptr         <= '0;
      r_word_count  <= '0;
      r_cycle_count <= '0;
      r_hold_cnt    <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_ptr         <= '0;
        r_word_count  <= '0;
        r_cycle_count <= '0;
        r_done        <= 1'b0;
        r_timeout     <= 1'b0;
      end
      if (w_accept) begin
        r_word_count <= r_word_count + WC_W'(1);
        if (r_ptr != LAST_ADDR) r_ptr <= r_ptr + ADDR_W'(1);
      end
      if (r_state == S_LOAD)      r_hold_cnt <= '0;
      else if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      if (r_state == S_RUN) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
        if (w_halt)        r_done    <= 1'b1;
        else if (w_budget) r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl: default, short-budget and shallow-imem instances
// share one stimulus stream; each scenario checks the instance it targets.
module tb_prog_loader_ctrl;

  logic        clk;
  logic        clr;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic [31:0] core_IR;

  logic        a_ld_ready, a_imem_we, a_clr_PC, a_busy, a_done, a_timeout;
  logic [9:0]  a_imem_addr;
  logic [31:0] a_imem_wdata;
  logic [10:0] a_word_count;
  logic [31:0] a_cycle_count;

  logic        b_ld_ready, b_imem_we, b_clr_PC, b_busy, b_done, b_timeout;
  logic [9:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic [10:0] b_word_count;
  logic [31:0] b_cycle_count;

  logic        c_ld_ready, c_imem_we, c_clr_PC, c_busy, c_done, c_timeout;
  logic [2:0]  c_imem_addr;
  logic [31:0] c_imem_wdata;
  logic [3:0]  c_word_count;
  logic [31:0] c_cycle_count;

  int n_checks;
  int n_errors;

  logic [31:0] prog [7];

  prog_loader_ctrl dut_a (
    .clk(clk), .clr(clr), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(a_ld_ready), .imem_we(a_imem_we),
    .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata), .core_IR(core_IR),
    .clr_PC(a_clr_PC), .busy(a_busy), .done(a_done), .timeout(a_timeout),
    .word_count(a_word_count), .cycle_count(a_cycle_count)
  );

  prog_loader_ctrl #(.MAX_CYCLES(16)) dut_b (
    .clk(clk), .clr(clr), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(b_ld_ready), .imem_we(b_imem_we),
    .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata), .core_IR(core_IR),
    .clr_PC(b_clr_PC), .busy(b_busy), .done(b_done), .timeout(b_timeout),
    .word_count(b_word_count), .cycle_count(b_cycle_count)
  );

  prog_loader_ctrl #(.ADDR_W(3)) dut_c (
    .clk(clk), .clr(clr), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(c_ld_ready), .imem_we(c_imem_we),
    .imem_addr(c_imem_addr), .imem_wdata(c_imem_wdata), .core_IR(core_IR),
    .clr_PC(c_clr_PC), .busy(c_busy), .done(c_done), .timeout(c_timeout),
    .word_count(c_word_count), .cycle_count(c_cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr      = 1'b1;
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    core_IR  = '0;
    prog[0] = 32'h200100c8; prog[1] = 32'h28020001; prog[2] = 32'h14411000;
    prog[3] = 32'h2c210001; prog[4] = 32'h3420fffd; prog[5] = 32'h240200c6;
    prog[6] = 32'hfc000000;

    // Reset state
    tick();
    tick();
    chk("rst_clr_pc", 64'(a_clr_PC), 64'd1);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_timeout", 64'(a_timeout), 64'd0);
    chk("rst_wc", 64'(a_word_count), 64'd0);
    chk("rst_cc", 64'(a_cycle_count), 64'd0);
    chk("rst_ld_ready", 64'(a_ld_ready), 64'd0);
    clr = 1'b0;
    tick();

    // Seven-word image with ld_last on the final word
    start_load();
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = (i == 6);
      #1;
      chk("load_we", 64'(a_imem_we), 64'd1);
      chk("load_addr", 64'(a_imem_addr), 64'(i));
      chk("load_wdata", 64'(a_imem_wdata), 64'(prog[i]));
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("load_wc", 64'(a_word_count), 64'd7);
    chk("hold1_clr_pc", 64'(a_clr_PC), 64'd1);
    chk("hold1_ld_ready", 64'(a_ld_ready), 64'd0);
    chk("hold1_we", 64'(a_imem_we), 64'd0);
    tick();
    chk("hold2_clr_pc", 64'(a_clr_PC), 64'd1);
    tick();
    chk("run_clr_pc", 64'(a_clr_PC), 64'd0);
    chk("run_busy", 64'(a_busy), 64'd1);

    // Halt fetched on the 10th RUN cycle; start during RUN must be ignored
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_ign_busy", 64'(a_busy), 64'd1);
    chk("run_start_ign_cc", 64'(a_cycle_count), 64'd3);
    chk("run_start_ign_pc", 64'(a_clr_PC), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    core_IR = 32'hfc000000;
    tick();
    core_IR = 32'h0;
    chk("halt_done", 64'(a_done), 64'd1);
    chk("halt_cc", 64'(a_cycle_count), 64'd10);
    chk("halt_clr_pc", 64'(a_clr_PC), 64'd1);
    chk("halt_timeout", 64'(a_timeout), 64'd0);
    chk("halt_busy", 64'(a_busy), 64'd0);
    tick();
    chk("halt_cc_frozen", 64'(a_cycle_count), 64'd10);

    // Budget of 16 without halt, then halt on the final budget cycle
    pulse_clr();
    start_load();
    push(32'h00000000, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_pre_timeout", 64'(b_timeout), 64'd0);
    chk("to_pre_cc", 64'(b_cycle_count), 64'd15);
    tick();
    chk("to_timeout", 64'(b_timeout), 64'd1);
    chk("to_cc", 64'(b_cycle_count), 64'd16);
    chk("to_done", 64'(b_done), 64'd0);
    chk("to_clr_pc", 64'(b_clr_PC), 64'd1);
    tick();
    chk("to_cc_frozen", 64'(b_cycle_count), 64'd16);
    start_load();
    chk("restart_timeout_clr", 64'(b_timeout), 64'd0);
    chk("restart_cc_clr", 64'(b_cycle_count), 64'd0);
    chk("restart_busy", 64'(b_busy), 64'd1);
    push(32'h00000000, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    core_IR = 32'hfc000000;
    tick();
    core_IR = 32'h0;
    chk("edge_done", 64'(b_done), 64'd1);
    chk("edge_timeout", 64'(b_timeout), 64'd0);
    chk("edge_cc", 64'(b_cycle_count), 64'd16);

    // Full-depth load without ld_last on the 8-deep instance
    pulse_clr();
    start_load();
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h00001000 + 32'(i);
      ld_last  = 1'b0;
      #1;
      if (i < 8) begin
        chk("full_we", 64'(c_imem_we), 64'd1);
        chk("full_addr", 64'(c_imem_addr), 64'(i));
      end else begin
        chk("full_we_off", 64'(c_imem_we), 64'd0);
        chk("full_ready_off", 64'(c_ld_ready), 64'd0);
      end
      tick();
    end
    ld_valid = 1'b0;
    chk("full_wc", 64'(c_word_count), 64'd8);

    // Abort mid-load with clr, then reload from address 0
    pulse_clr();
    start_load();
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b0);
    push(32'h33333333, 1'b0);
    clr = 1'b1;
    #1;
    chk("abort_busy", 64'(a_busy), 64'd0);
    chk("abort_wc", 64'(a_word_count), 64'd0);
    chk("abort_clr_pc", 64'(a_clr_PC), 64'd1);
    tick();
    clr = 1'b0;
    start_load();
    ld_valid = 1'b1;
    ld_data  = 32'h44444444;
    #1;
    chk("reload_addr", 64'(a_imem_addr), 64'd0);
    tick();
    push(32'h55555555, 1'b1);
    chk("reload_wc", 64'(a_word_count), 64'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
